// File: rtl/shot_launcher.sv
// Missile spawner/mover: up to MAX_SHOTS shots launched from the ship along its heading, Q.6 positions.
// Define SHOT_WRAP_EN to wrap shots at screen edges; otherwise a shot leaving the screen retires.
module shot_launcher #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int MAX_SHOTS  = 4,
    parameter int SHOT_SPEED = 8,
    parameter int LIFETIME   = 48,
    parameter int COOLDOWN   = 6
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         frame_pulse,
    input  logic                                         game_over,
    input  logic                                         fire,
    input  logic [$clog2(WIDTH)-1:0]                     ship_x,
    input  logic [$clog2(HEIGHT)-1:0]                    ship_y,
    input  logic signed [17:0]                           sin_val,
    input  logic signed [17:0]                           cos_val,
    input  logic [MAX_SHOTS-1:0]                         shot_hit,
    output logic [MAX_SHOTS-1:0]                         shot_valid,
    output logic [MAX_SHOTS-1:0][$clog2(WIDTH)-1:0]      shot_x,
    output logic [MAX_SHOTS-1:0][$clog2(HEIGHT)-1:0]     shot_y,
    output logic                                         fire_snd
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int PW = 18;
    localparam int VW = 13;
    localparam logic signed [PW-1:0] X_LIM = PW'(WIDTH * 64);
    localparam logic signed [PW-1:0] Y_LIM = PW'(HEIGHT * 64);
    localparam logic [7:0] LIFE_INIT = 8'(LIFETIME);
    localparam logic [5:0] CD_INIT   = 6'(COOLDOWN);

    logic                 fire_q;
    logic [5:0]           cd_q;
    logic                 fire_snd_q;
    logic [MAX_SHOTS-1:0] valid_q;
    logic [MAX_SHOTS-1:0] free_slots;
    logic [MAX_SHOTS-1:0] launch_sel;
    logic                 launch_ok;

    // Velocity: 18x4 signed product, arithmetic shift by 10 gives Q.6 pixels/frame.
    logic signed [22:0] cos_ext, sin_ext, speed_ext, vx_prod, vy_prod;
    logic signed [VW-1:0] vx_new, vy_new;

    assign cos_ext   = {{5{cos_val[17]}}, cos_val};
    assign sin_ext   = {{5{sin_val[17]}}, sin_val};
    assign speed_ext = 23'(SHOT_SPEED);
    assign vx_prod   = cos_ext * speed_ext;
    assign vy_prod   = sin_ext * speed_ext;
    assign vx_new    = vx_prod[22:10];
    assign vy_new    = vy_prod[22:10];

    // A slot being hit this cycle is not offered for launch.
    assign free_slots = ~valid_q & ~shot_hit;
    assign launch_ok  = fire & ~fire_q & (cd_q == 6'd0) & ~game_over & (|free_slots);
    assign launch_sel = launch_ok ? (free_slots & (~free_slots + MAX_SHOTS'(1))) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            fire_q     <= 1'b0;
            cd_q       <= 6'd0;
            fire_snd_q <= 1'b0;
        end else begin
            fire_q     <= fire;
            fire_snd_q <= launch_ok;
            if (game_over)
                cd_q <= 6'd0;
            else if (launch_ok)
                cd_q <= CD_INIT;
            else if (frame_pulse && cd_q != 6'd0)
                cd_q <= cd_q - 6'd1;
        end
    end

    assign fire_snd   = fire_snd_q;
    assign shot_valid = valid_q;

    generate
        for (genvar gi = 0; gi < MAX_SHOTS; gi++) begin : g_slot
            logic                 v_q, v_d;
            logic signed [PW-1:0] px_q, px_d, py_q, py_d;
            logic signed [VW-1:0] vx_q, vx_d, vy_q, vy_d;
            logic [7:0]           life_q, life_d, life_dec;
            logic signed [PW-1:0] px_adv, py_adv, px_fix, py_fix;
            logic                 leave;

            always_comb begin
                v_d      = v_q;
                px_d     = px_q;
                py_d     = py_q;
                vx_d     = vx_q;
                vy_d     = vy_q;
                life_d   = life_q;
                life_dec = life_q - 8'd1;
                px_adv   = px_q + PW'(vx_q);
                py_adv   = py_q + PW'(vy_q);
`ifdef SHOT_WRAP_EN
                leave  = 1'b0;
                px_fix = px_adv;
                py_fix = py_adv;
                if (px_adv < 0)
                    px_fix = px_adv + X_LIM;
                else if (px_adv >= X_LIM)
                    px_fix = px_adv - X_LIM;
                if (py_adv < 0)
                    py_fix = py_adv + Y_LIM;
                else if (py_adv >= Y_LIM)
                    py_fix = py_adv - Y_LIM;
`else
                px_fix = px_adv;
                py_fix = py_adv;
                leave  = (px_adv < 0) || (px_adv >= X_LIM) || (py_adv < 0) || (py_adv >= Y_LIM);
`endif
                if (game_over || shot_hit[gi]) begin
                    v_d = 1'b0;
                end else if (launch_sel[gi]) begin
                    v_d    = 1'b1;
                    px_d   = PW'({ship_x, 6'b0});
                    py_d   = PW'({ship_y, 6'b0});
                    vx_d   = vx_new;
                    vy_d   = vy_new;
                    life_d = LIFE_INIT;
                end else if (frame_pulse && v_q) begin
                    life_d = life_dec;
                    px_d   = px_fix;
                    py_d   = py_fix;
                    if (life_dec == 8'd0 || leave)
                        v_d = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    v_q    <= 1'b0;
                    px_q   <= '0;
                    py_q   <= '0;
                    vx_q   <= '0;
                    vy_q   <= '0;
                    life_q <= 8'd0;
                end else begin
                    v_q    <= v_d;
                    px_q   <= px_d;
                    py_q   <= py_d;
                    vx_q   <= vx_d;
                    vy_q   <= vy_d;
                    life_q <= life_d;
                end
            end

            assign valid_q[gi] = v_q;
            assign shot_x[gi]  = px_q[XW+5:6];
            assign shot_y[gi]  = py_q[YW+5:6];
        end
    endgenerate
endmodule

// File: tb/tb_shot_launcher.sv
// Directed bench for shot_launcher (default parameters); edge case follows SHOT_WRAP_EN if defined.
module tb_shot_launcher;
    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              frame_pulse = 1'b0;
    logic              game_over = 1'b0;
    logic              fire = 1'b0;
    logic [9:0]        ship_x = '0;
    logic [8:0]        ship_y = '0;
    logic signed [17:0] sin_val = '0;
    logic signed [17:0] cos_val = '0;
    logic [3:0]        shot_hit = '0;
    logic [3:0]        shot_valid;
    logic [3:0][9:0]   shot_x;
    logic [3:0][8:0]   shot_y;
    logic              fire_snd;

    int total = 0;
    int bad   = 0;
    logic snd;

    shot_launcher dut (
        .clk        (clk),
        .reset      (reset),
        .frame_pulse(frame_pulse),
        .game_over  (game_over),
        .fire       (fire),
        .ship_x     (ship_x),
        .ship_y     (ship_y),
        .sin_val    (sin_val),
        .cos_val    (cos_val),
        .shot_hit   (shot_hit),
        .shot_valid (shot_valid),
        .shot_x     (shot_x),
        .shot_y     (shot_y),
        .fire_snd   (fire_snd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_pulse = 1'b1;
            tick();
        end
        frame_pulse = 1'b0;
    endtask

    // Fire rising edge held one cycle; returns fire_snd seen right after the launch edge.
    task automatic press(output logic s);
        fire = 1'b1;
        tick();
        s = fire_snd;
        fire = 1'b0;
        tick();
    endtask

    initial begin
        repeat (4) tick();
        chk("rst_valid", 32'(shot_valid), 32'd0);
        chk("rst_snd", 32'(fire_snd), 32'd0);
        chk("rst_x0", 32'(shot_x[0]), 32'd0);
        reset = 1'b0;
        tick();

        // Basic launch along +x
        ship_x = 10'd320; ship_y = 9'd240; cos_val = 18'sd65536; sin_val = '0;
        fire = 1'b1;
        tick();
        chk("launch_snd", 32'(fire_snd), 32'd1);
        chk("launch_valid", 32'(shot_valid), 32'h1);
        chk("launch_x0", 32'(shot_x[0]), 32'd320);
        chk("launch_y0", 32'(shot_y[0]), 32'd240);
        fire = 1'b0;
        tick();
        chk("snd_one_cycle", 32'(fire_snd), 32'd0);
        frames(3);
        chk("move_x0", 32'(shot_x[0]), 32'd344);
        chk("move_y0", 32'(shot_y[0]), 32'd240);

        // Cooldown: 3 frames after launch is too soon, 6 frames is enough
        press(snd);
        chk("cd_early_snd", 32'(snd), 32'd0);
        chk("cd_early_valid", 32'(shot_valid), 32'h1);
        frames(3);
        press(snd);
        chk("cd_ok_snd", 32'(snd), 32'd1);
        chk("cd_ok_valid", 32'(shot_valid), 32'h3);
        chk("cd_ok_x1", 32'(shot_x[1]), 32'd320);

        // game_over clears everything and blocks a concurrent press
        game_over = 1'b1;
        fire = 1'b1;
        tick();
        chk("go_valid", 32'(shot_valid), 32'd0);
        chk("go_snd", 32'(fire_snd), 32'd0);
        game_over = 1'b0;
        fire = 1'b0;
        tick();

        // Fill all four slots, fifth press dropped
        cos_val = '0; sin_val = '0;
        for (int k = 0; k < 5; k++) begin
            press(snd);
            chk($sformatf("fill%0d_snd", k), 32'(snd), (k < 4) ? 32'd1 : 32'd0);
            chk($sformatf("fill%0d_valid", k), 32'(shot_valid), (k < 4) ? ((32'd1 << (k + 1)) - 32'd1) : 32'hF);
            frames(6);
        end

        // Reset mid-flight, then the next launch lands in slot 0
        reset = 1'b1;
        tick();
        chk("mrst_valid", 32'(shot_valid), 32'd0);
        chk("mrst_x3", 32'(shot_x[3]), 32'd0);
        chk("mrst_y1", 32'(shot_y[1]), 32'd0);
        reset = 1'b0;
        tick();
        ship_x = 10'd100; ship_y = 9'd50;
        press(snd);
        chk("post_rst_snd", 32'(snd), 32'd1);
        chk("post_rst_valid", 32'(shot_valid), 32'h1);
        chk("post_rst_x0", 32'(shot_x[0]), 32'd100);

        // Hit concurrent with frame pulse clears the slot
        shot_hit = 4'b0001;
        frame_pulse = 1'b1;
        tick();
        shot_hit = '0;
        frame_pulse = 1'b0;
        chk("hit_valid", 32'(shot_valid), 32'd0);

        // Lifetime: 47 frames alive, gone on the 48th
        frames(6);
        ship_x = 10'd200; ship_y = 9'd100;
        press(snd);
        chk("life_snd", 32'(snd), 32'd1);
        frames(47);
        chk("life47_valid", 32'(shot_valid), 32'h1);
        frames(1);
        chk("life48_valid", 32'(shot_valid), 32'd0);

        // Launch on a frame-pulse cycle is not advanced that frame
        ship_x = 10'd320; ship_y = 9'd240; cos_val = 18'sd65536; sin_val = '0;
        fire = 1'b1;
        frame_pulse = 1'b1;
        tick();
        fire = 1'b0;
        frame_pulse = 1'b0;
        chk("fp_launch_valid", 32'(shot_valid), 32'h1);
        chk("fp_launch_x0", 32'(shot_x[0]), 32'd320);
        tick();

        // Upward shot (negative sine)
        frames(6);
        chk("fp_after6_x0", 32'(shot_x[0]), 32'd368);
        cos_val = '0; sin_val = -18'sd65536;
        press(snd);
        chk("up_valid", 32'(shot_valid), 32'h3);
        frames(1);
        chk("up_y1", 32'(shot_y[1]), 32'd232);
        chk("up_x1", 32'(shot_x[1]), 32'd320);

        // Right screen edge
        frames(5);
        ship_x = 10'd635; ship_y = 9'd10; cos_val = 18'sd65536; sin_val = '0;
        press(snd);
        chk("edge_launch_x2", 32'(shot_x[2]), 32'd635);
        chk("edge_launch_v2", 32'(shot_valid[2]), 32'd1);
        frames(1);
`ifdef SHOT_WRAP_EN
        chk("edge_wrap_v2", 32'(shot_valid[2]), 32'd1);
        chk("edge_wrap_x2", 32'(shot_x[2]), 32'd3);
`else
        chk("edge_exit_v2", 32'(shot_valid[2]), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
